// File: rtl/axil_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_arb_pkg
// Description : Shared types and AXI4-Lite constants for the master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WR_B = 3'd2,
        ST_RD_A = 3'd3,
        ST_RD_R = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axil_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_arbiter_if
// Description : Requester command/response bus plus the AXI4-Lite master port.
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_master_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requester side
    logic [N_REQ-1:0]            REQ_VALID;
    logic [N_REQ-1:0]            REQ_WRITE;
    logic [N_REQ*ADDR_W-1:0]     REQ_ADDR;
    logic [N_REQ*DATA_W-1:0]     REQ_WDATA;
    logic [N_REQ*DATA_W/8-1:0]   REQ_WSTRB;
    logic [N_REQ-1:0]            REQ_READY;
    logic [N_REQ-1:0]            RSP_VALID;
    logic [DATA_W-1:0]           RSP_RDATA;
    logic                        RSP_ERR;
    logic                        BUSY;
    logic                        ERROR;
    logic                        ERR_CLR;

    // AXI4-Lite master port
    logic [ADDR_W-1:0]           M_AXI_AWADDR;
    logic [2:0]                  M_AXI_AWPROT;
    logic                        M_AXI_AWVALID;
    logic                        M_AXI_AWREADY;
    logic [DATA_W-1:0]           M_AXI_WDATA;
    logic [DATA_W/8-1:0]         M_AXI_WSTRB;
    logic                        M_AXI_WVALID;
    logic                        M_AXI_WREADY;
    logic [1:0]                  M_AXI_BRESP;
    logic                        M_AXI_BVALID;
    logic                        M_AXI_BREADY;
    logic [ADDR_W-1:0]           M_AXI_ARADDR;
    logic [2:0]                  M_AXI_ARPROT;
    logic                        M_AXI_ARVALID;
    logic                        M_AXI_ARREADY;
    logic [DATA_W-1:0]           M_AXI_RDATA;
    logic [1:0]                  M_AXI_RRESP;
    logic                        M_AXI_RVALID;
    logic                        M_AXI_RREADY;

    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_WSTRB, ERR_CLR,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY, ERROR,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_WSTRB, ERR_CLR,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY, ERROR,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface
`default_nettype wire

// File: rtl/axil_master_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first request at or after
//               the pointer, searching cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_rr_ptr,
    output logic      [N-1:0]  o_grant,
    output logic      [IW-1:0] o_grant_idx
);

    // Walk offsets from far to near so the nearest asserted request wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int              w_sum;
            logic [IW-1:0]   w_idx;
            w_sum = int'(i_rr_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = w_sum[IW-1:0];
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_arbiter
// Description : Round-robin sharing of one AXI4-Lite master among N_REQ
//               single-beat requesters, one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master_arbiter
    import axil_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic             ACLK,
    input  wire logic             ARESET,
    axil_master_arbiter_if.master bus
);

    localparam int IW     = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    state_t              r_state;
    state_t              w_next;
    logic [N_REQ-1:0]    w_grant;
    logic [IW-1:0]       w_grant_idx;
    logic                w_any;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_rsp_err;

    logic [IW-1:0]       r_rr_ptr;
    logic [N_REQ-1:0]    r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_resp;
    logic                r_aw_done;
    logic                r_w_done;
    logic                r_error;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req       (bus.REQ_VALID),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_any     = |bus.REQ_VALID;
    // Handshakes derived from registers so they never loop back through the
    // valid outputs.
    assign w_aw_hs   = (r_state == ST_WR) && !r_aw_done && bus.M_AXI_AWREADY;
    assign w_w_hs    = (r_state == ST_WR) && !r_w_done  && bus.M_AXI_WREADY;
    assign w_rsp_err = (r_state == ST_RSP) && (r_resp != AXI_RESP_OKAY);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        bus.REQ_READY      = '0;
        bus.RSP_VALID      = '0;
        bus.RSP_ERR        = 1'b0;
        bus.M_AXI_AWVALID  = 1'b0;
        bus.M_AXI_WVALID   = 1'b0;
        bus.M_AXI_BREADY   = 1'b0;
        bus.M_AXI_ARVALID  = 1'b0;
        bus.M_AXI_RREADY   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.REQ_READY = w_grant;
                if (w_any) begin
                    w_next = bus.REQ_WRITE[w_grant_idx] ? ST_WR : ST_RD_A;
                end
            end
            ST_WR: begin
                bus.M_AXI_AWVALID = !r_aw_done;
                bus.M_AXI_WVALID  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next = ST_WR_B;
                end
            end
            ST_WR_B: begin
                bus.M_AXI_BREADY = 1'b1;
                if (bus.M_AXI_BVALID) begin
                    w_next = ST_RSP;
                end
            end
            ST_RD_A: begin
                bus.M_AXI_ARVALID = 1'b1;
                if (bus.M_AXI_ARREADY) begin
                    w_next = ST_RD_R;
                end
            end
            ST_RD_R: begin
                bus.M_AXI_RREADY = 1'b1;
                if (bus.M_AXI_RVALID) begin
                    w_next = ST_RSP;
                end
            end
            ST_RSP: begin
                bus.RSP_VALID = r_gnt;
                bus.RSP_ERR   = (r_resp != AXI_RESP_OKAY);
                w_next        = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= AXI_RESP_OKAY;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_any) begin
                r_gnt     <= w_grant;
                r_addr    <= bus.REQ_ADDR[w_grant_idx*ADDR_W +: ADDR_W];
                r_wdata   <= bus.REQ_WDATA[w_grant_idx*DATA_W +: DATA_W];
                r_wstrb   <= bus.REQ_WSTRB[w_grant_idx*STRB_W +: STRB_W];
                r_rr_ptr  <= (w_grant_idx == IW'(N_REQ - 1)) ? '0 : w_grant_idx + IW'(1);
                r_rdata   <= '0;
                r_resp    <= AXI_RESP_OKAY;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if ((r_state == ST_WR_B) && bus.M_AXI_BVALID) begin
                r_resp <= bus.M_AXI_BRESP;
            end
            if ((r_state == ST_RD_R) && bus.M_AXI_RVALID) begin
                r_rdata <= bus.M_AXI_RDATA;
                r_resp  <= bus.M_AXI_RRESP;
            end
            // A new error outranks a simultaneous clear.
            if (w_rsp_err) begin
                r_error <= 1'b1;
            end else if (bus.ERR_CLR) begin
                r_error <= 1'b0;
            end
        end
    end

    assign bus.M_AXI_AWADDR = r_addr;
    assign bus.M_AXI_AWPROT = PROT_DEFAULT;
    assign bus.M_AXI_WDATA  = r_wdata;
    assign bus.M_AXI_WSTRB  = r_wstrb;
    assign bus.M_AXI_ARADDR = r_addr;
    assign bus.M_AXI_ARPROT = PROT_DEFAULT;
    assign bus.RSP_RDATA    = r_rdata;
    assign bus.BUSY         = (r_state != ST_IDLE);
    assign bus.ERROR        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_axil_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_master_arbiter
// Description : Directed bench with a memory-mode AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_master_arbiter;
    import axil_arb_pkg::*;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_master_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axil_master_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------ slave
    logic [31:0] mem [16];
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          b_delay  = 0;
    logic [1:0]  bresp_cfg = AXI_RESP_OKAY;
    int          aw_cnt = 0, w_cnt = 0, b_wait = 0;
    int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
    logic        s_aw_got = 1'b0, s_w_got = 1'b0, b_pend = 1'b0;
    logic        m_aw = 1'b0, m_w = 1'b0;
    logic [31:0] s_awaddr = '0, s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_bvalid = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = '0, s_rresp = '0;
    logic [31:0] s_rdata = '0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic        aw_hs, w_hs, aw_ok, w_ok;
    logic [31:0] cur_awaddr, cur_wdata;
    logic [3:0]  cur_wstrb;

    assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_delay);
    assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt >= w_delay);
    assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID;
    assign bus.M_AXI_BVALID  = s_bvalid;
    assign bus.M_AXI_BRESP   = s_bresp;
    assign bus.M_AXI_RVALID  = s_rvalid;
    assign bus.M_AXI_RDATA   = s_rdata;
    assign bus.M_AXI_RRESP   = s_rresp;

    assign aw_hs      = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
    assign w_hs       = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
    assign aw_ok      = s_aw_got || aw_hs;
    assign w_ok       = s_w_got || w_hs;
    assign cur_awaddr = aw_hs ? bus.M_AXI_AWADDR : s_awaddr;
    assign cur_wdata  = w_hs ? bus.M_AXI_WDATA : s_wdata;
    assign cur_wstrb  = w_hs ? bus.M_AXI_WSTRB : s_wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            b_pend <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            m_aw <= 1'b0; m_w <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1; last_awaddr <= bus.M_AXI_AWADDR; m_aw <= 1'b1;
            end else if (bus.M_AXI_AWVALID) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_cnt <= 0; w_hs_n <= w_hs_n + 1; last_wdata <= bus.M_AXI_WDATA; m_w <= 1'b1;
            end else if (bus.M_AXI_WVALID) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_ok && w_ok) begin
                mem[cur_awaddr[5:2]] <= merge(mem[cur_awaddr[5:2]], cur_wdata, cur_wstrb);
                s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bresp <= bresp_cfg;
                if (b_delay == 0) s_bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_wait <= b_delay - 1; end
            end else begin
                s_aw_got <= aw_ok; s_w_got <= w_ok;
                if (aw_hs) s_awaddr <= bus.M_AXI_AWADDR;
                if (w_hs) begin s_wdata <= bus.M_AXI_WDATA; s_wstrb <= bus.M_AXI_WSTRB; end
            end
            if (b_pend) begin
                if (b_wait == 0) begin s_bvalid <= 1'b1; b_pend <= 1'b0; end
                else b_wait <= b_wait - 1;
            end
            if (s_bvalid && bus.M_AXI_BREADY) begin
                s_bvalid <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0;
            end
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                s_rvalid <= 1'b1; s_rdata <= mem[bus.M_AXI_ARADDR[5:2]]; s_rresp <= AXI_RESP_OKAY;
                last_araddr <= bus.M_AXI_ARADDR; ar_hs_n <= ar_hs_n + 1;
            end else if (s_rvalid && bus.M_AXI_RREADY) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    int grant_log[$];
    int ready_viol  = 0;
    int bready_viol = 0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++)
                if (bus.REQ_READY[i] && bus.REQ_VALID[i]) grant_log.push_back(i);
            if ($countones(bus.REQ_READY) > 1 || (bus.REQ_READY != '0 && bus.BUSY))
                ready_viol <= ready_viol + 1;
            if (bus.M_AXI_BREADY && !(m_aw && m_w))
                bready_viol <= bready_viol + 1;
        end
    end

    // ------------------------------------------------------------------ tasks
    task automatic do_cmd(input int idx, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic clr_on_rsp,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        lat = -1; rdata = '0; err = 1'b0;
        @(posedge clk); #1;
        bus.REQ_VALID[idx] = 1'b1;
        bus.REQ_WRITE[idx] = wr;
        bus.REQ_ADDR[idx*ADDR_W +: ADDR_W]    = addr;
        bus.REQ_WDATA[idx*DATA_W +: DATA_W]   = wdata;
        bus.REQ_WSTRB[idx*DATA_W/8 +: DATA_W/8] = wstrb;
        #1;
        n = 0;
        while (!bus.REQ_READY[idx] && n < 200) begin @(posedge clk); #2; n++; end
        if (!bus.REQ_READY[idx]) begin bus.REQ_VALID[idx] = 1'b0; return; end
        @(posedge clk); #1;
        bus.REQ_VALID[idx] = 1'b0;
        n = 1;
        while (!bus.RSP_VALID[idx] && n < 200) begin @(posedge clk); #1; n++; end
        if (bus.RSP_VALID[idx]) begin
            lat = n; rdata = bus.RSP_RDATA; err = bus.RSP_ERR;
            if (clr_on_rsp) bus.ERR_CLR = 1'b1;
        end
        @(posedge clk); #1;
        bus.ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.BUSY, bus.ERROR} !== '0) begin
            failures++; $display("FAIL reset_status got=%b exp=0",
                {bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.BUSY, bus.ERROR});
        end
        checks++;
        if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
             bus.M_AXI_RREADY} !== 5'b0) begin
            failures++; $display("FAIL reset_axi_valids got=%b exp=00000",
                {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY});
        end
        checks++;
        if (bus.RSP_RDATA !== 32'h0 || bus.M_AXI_AWADDR !== 32'h0 || bus.M_AXI_WDATA !== 32'h0) begin
            failures++; $display("FAIL reset_regs rdata=%h awaddr=%h wdata=%h exp=0",
                bus.RSP_RDATA, bus.M_AXI_AWADDR, bus.M_AXI_WDATA);
        end
        checks++;
        if (bus.M_AXI_AWPROT !== 3'b000 || bus.M_AXI_ARPROT !== 3'b000) begin
            failures++; $display("FAIL reset_prot aw=%b ar=%b exp=000", bus.M_AXI_AWPROT, bus.M_AXI_ARPROT);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_basic();
        logic [31:0] rd; logic er; int lat; int aw0, w0;
        aw0 = aw_hs_n; w0 = w_hs_n;
        do_cmd(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            failures++; $display("FAIL wr_rsp err=%b rdata=%h exp err=0 rdata=0", er, rd);
        end
        checks++;
        if (last_awaddr !== 32'h10 || last_wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_beat awaddr=%h wdata=%h exp 10/deadbeef", last_awaddr, last_wdata);
        end
        checks++;
        if (aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1) begin
            failures++; $display("FAIL wr_hs_count aw=%0d w=%0d exp 1/1", aw_hs_n - aw0, w_hs_n - w0);
        end
        checks++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[4]);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd; logic er; int lat;
        do_cmd(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, er, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
        checks++;
        if (last_araddr !== 32'h10) begin failures++; $display("FAIL rd_araddr got=%h exp=10", last_araddr); end
    endtask

    task automatic test_round_robin();
        int exp_rr[6];
        int n;
        exp_rr = '{0, 1, 2, 0, 1, 2};
        rst = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            bus.REQ_WRITE[i] = 1'b1;
            bus.REQ_ADDR[i*ADDR_W +: ADDR_W]  = 32'h20 + 32'(i * 4);
            bus.REQ_WDATA[i*DATA_W +: DATA_W] = 32'h1000 + 32'(i);
            bus.REQ_WSTRB[i*4 +: 4] = 4'hF;
        end
        bus.REQ_VALID = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        grant_log.delete();
        rst = 1'b0;
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin @(posedge clk); #1; n++; end
        bus.REQ_VALID = '0;
        n = 0;
        while (bus.BUSY && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (grant_log.size() < 6 || bus.BUSY !== 1'b0) begin
            failures++; $display("FAIL rr_progress grants=%0d busy=%b exp >=6/0", grant_log.size(), bus.BUSY);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) begin
                checks++;
                if (grant_log[i] !== exp_rr[i]) begin
                    failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, grant_log[i], exp_rr[i]);
                end
            end
        end
        checks++;
        if (ready_viol !== 0) begin failures++; $display("FAIL req_ready_onehot violations=%0d exp=0", ready_viol); end
    endtask

    task automatic test_wr_stall();
        int awd[3]; int wd[3];
        logic [31:0] rd; logic er; int lat; int aw0, w0, bv0, exp_lat;
        awd = '{0, 5, 2};
        wd  = '{5, 0, 2};
        for (int k = 0; k < 3; k++) begin
            aw_delay = awd[k]; w_delay = wd[k];
            aw0 = aw_hs_n; w0 = w_hs_n; bv0 = bready_viol;
            exp_lat = 3 + ((awd[k] > wd[k]) ? awd[k] : wd[k]);
            do_cmd(2, 1'b1, 32'h30 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 4'hF, 1'b0, rd, er, lat);
            checks++;
            if (aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1) begin
                failures++; $display("FAIL stall%0d_hs_count aw=%0d w=%0d exp 1/1", k, aw_hs_n - aw0, w_hs_n - w0);
            end
            checks++;
            if (lat !== exp_lat) begin failures++; $display("FAIL stall%0d_latency got=%0d exp=%0d", k, lat, exp_lat); end
            checks++;
            if (bready_viol !== bv0) begin
                failures++; $display("FAIL stall%0d_bready_early got=%0d exp=0", k, bready_viol - bv0);
            end
            checks++;
            if (mem[12 + k] !== 32'hA5A5_0000 + 32'(k)) begin
                failures++; $display("FAIL stall%0d_mem got=%h exp=%h", k, mem[12 + k], 32'hA5A5_0000 + 32'(k));
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_error();
        logic [31:0] rd; logic er; int lat;
        bresp_cfg = AXI_RESP_SLVERR;
        do_cmd(0, 1'b1, 32'h3C, 32'h0BAD_0BAD, 4'hF, 1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || lat !== 3) begin failures++; $display("FAIL err_rsp err=%b lat=%0d exp 1/3", er, lat); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ERROR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.ERROR); end
        bus.ERR_CLR = 1'b1;
        @(posedge clk); #1;
        bus.ERR_CLR = 1'b0;
        checks++;
        if (bus.ERROR !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus.ERROR); end
        do_cmd(1, 1'b1, 32'h3C, 32'h0BAD_0BAD, 4'hF, 1'b1, rd, er, lat);
        checks++;
        if (er !== 1'b1 || bus.ERROR !== 1'b1) begin
            failures++; $display("FAIL err_set_wins err=%b error=%b exp 1/1", er, bus.ERROR);
        end
        bresp_cfg = AXI_RESP_OKAY;
        bus.ERR_CLR = 1'b1;
        @(posedge clk); #1;
        bus.ERR_CLR = 1'b0;
        do_cmd(2, 1'b1, 32'h3C, 32'h600D_600D, 4'h3, 1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || bus.ERROR !== 1'b0 || mem[15] !== 32'h0BAD_600D) begin
            failures++; $display("FAIL err_okay_after err=%b error=%b mem=%h exp 0/0/0bad600d", er, bus.ERROR, mem[15]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int n;
        b_delay = 10;
        @(posedge clk); #1;
        bus.REQ_VALID[1] = 1'b1; bus.REQ_WRITE[1] = 1'b1;
        bus.REQ_ADDR[ADDR_W +: ADDR_W] = 32'h18; bus.REQ_WDATA[DATA_W +: DATA_W] = 32'h5555_AAAA;
        bus.REQ_WSTRB[4 +: 4] = 4'hF;
        #1;
        n = 0;
        while (!bus.REQ_READY[1] && n < 50) begin @(posedge clk); #2; n++; end
        @(posedge clk); #1;
        bus.REQ_VALID[1] = 1'b0;
        n = 0;
        while (!bus.M_AXI_BREADY && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.M_AXI_BREADY !== 1'b1) begin failures++; $display("FAIL rstmid_reach_wrb got=%b exp=1", bus.M_AXI_BREADY); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY} !== 5'b0) begin
            failures++; $display("FAIL rstmid_valids got=%b exp=00000",
                {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY});
        end
        checks++;
        if (bus.BUSY !== 1'b0 || bus.REQ_READY !== '0 || bus.RSP_VALID !== '0) begin
            failures++; $display("FAIL rstmid_status busy=%b req_ready=%b rsp_valid=%b exp 0", bus.BUSY, bus.REQ_READY, bus.RSP_VALID);
        end
        b_delay = 0;
        rst = 1'b0;
        do_cmd(1, 1'b1, 32'h14, 32'h1234_5678, 4'hF, 1'b0, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || mem[5] !== 32'h1234_5678) begin
            failures++; $display("FAIL rstmid_fresh_write lat=%0d err=%b mem=%h exp 3/0/12345678", lat, er, mem[5]);
        end
    endtask

    initial begin
        bus.REQ_VALID = '0;
        bus.REQ_WRITE = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        bus.REQ_WSTRB = '0;
        bus.ERR_CLR   = 1'b0;
        test_reset();
        test_write_basic();
        test_read();
        test_round_robin();
        test_wr_stall();
        test_error();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Shares one AXI4-Lite master port among N_REQ requesters in the text-overlay subsystem. Typical requesters are the character-RAM loader, the font/colour configurator and the CPU shim.
- Each requester issues single-beat read or write commands over a valid/ready command interface. The block arbitrates round-robin, runs exactly one AXI-Lite transaction at a time, and returns a per-requester response pulse.
- Sits between the overlay control logic and the AXI interconnect.
- Bench: an AXI VIP slave agent in memory mode.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (fixed at 32; WSTRB is DATA_W/8).

Ports:
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- REQ_VALID  in  N_REQ  command valid, one bit per requester.
- REQ_WRITE  in  N_REQ  1 = write, 0 = read.
- REQ_ADDR  in  N_REQ*ADDR_W  packed addresses; requester i is at slice [i*ADDR_W +: ADDR_W].
- REQ_WDATA  in  N_REQ*DATA_W  packed write data.
- REQ_WSTRB  in  N_REQ*DATA_W/8  packed byte strobes.
- REQ_READY  out  N_REQ  one-hot command accept.
- RSP_VALID  out  N_REQ  one-hot response pulse.
- RSP_RDATA  out  DATA_W  read data; shared, meaningful only with RSP_VALID.
- RSP_ERR  out  1  resp != OKAY; meaningful only with RSP_VALID.
- BUSY  out  1  a transaction is in flight.
- ERROR  out  1  sticky flag: any SLVERR/DECERR seen.
- ERR_CLR  in  1  clears ERROR.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY: standard AXI4-Lite write channels, master side.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels, master side.
- AWPROT and ARPROT are tied to 3'b000.

Behaviour:
- Reset (ARESET=1 at an edge):
  - state=IDLE, rr_ptr=0.
  - All AXI valid/ready outputs are 0, as are REQ_READY, RSP_VALID, RSP_ERR, BUSY and ERROR.
  - RSP_RDATA and the address/data registers are 0.
- Reset mid-transaction aborts immediately to IDLE. The bench must reset the slave at the same time.
- States: IDLE, WR (AW and W phase), WR_B, RD_A, RD_R, RSP.
- IDLE:
  - If any REQ_VALID is high, grant g = the first asserted index at or after rr_ptr, searching cyclically.
  - REQ_READY[g]=1 combinationally in that same cycle.
  - Latch addr/wdata/wstrb/write from requester g.
  - Set rr_ptr=(g+1) mod N_REQ.
  - Go to WR if write, else RD_A.
- Only one REQ_READY bit is ever high, and only in IDLE.
- WR:
  - AWVALID and WVALID are both asserted on the first cycle in WR, from registers.
  - Each valid drops independently on its own handshake; aw_done and w_done are tracked separately.
  - Go to WR_B once both handshakes are done, including when both complete in the same cycle.
  - VALID must never depend on READY.
- WR_B: BREADY=1. On BVALID, capture BRESP and go to RSP.
- RD_A: ARVALID=1 until ARREADY, then go to RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA and RRESP and go to RSP.
- RSP:
  - For one cycle: RSP_VALID[g]=1, RSP_RDATA = captured data (0 for writes), RSP_ERR = (resp != 2'b00).
  - Then go to IDLE.
- Minimum command-to-response latency with zero-wait slave:
  - Write: accept at cycle 0; AW/W at 1; B at 2; RSP_VALID at cycle 3.
  - Read: accept at 0; AR at 1; R at 2; RSP_VALID at 3.
- Back-to-back: the next grant can occur in the IDLE cycle right after RSP. Throughput is one transaction per 4 cycles at best.
- BUSY=1 in every state except IDLE.
- ERROR:
  - Set on an RSP cycle with RSP_ERR=1.
  - ERR_CLR clears it.
  - If set and clear occur in the same cycle, set wins.
- No timeout: a stalled slave holds the FSM indefinitely, which is legal AXI.
- A requester dropping REQ_VALID before it is granted is allowed; it simply is not granted.

Decomposition:
- Package axil_arb_pkg:
  - state_t enum.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - PROT_DEFAULT=3'b000.
- Sub-module rr_arbiter (N parameter):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.

Test Plan:
1. Requester 0 writes 0xDEADBEEF to 0x0000_0010 with WSTRB=0xF, zero-wait slave -> one AW/W beat with that address and data, RSP_VALID[0] at cycle 3, RSP_ERR=0; a slave memory read-back returns 0xDEADBEEF.
2. Requester 1 reads 0x0000_0010 after test 1 -> ARADDR=0x10, RSP_VALID[1] with RSP_RDATA=0xDEADBEEF.
3. All three requesters assert REQ_VALID continuously from reset -> grants in order 0,1,2,0,1,2; no requester is granted twice before the others.
4. Slave delays WREADY by 5 cycles and gives AWREADY immediately; then the reverse; then both in the same cycle -> exactly one AW and one W handshake each time, and BREADY only after both.
5. Slave returns BRESP=SLVERR -> RSP_ERR=1 and ERROR=1 held. ERR_CLR pulse -> ERROR=0. ERR_CLR asserted on an error RSP cycle -> ERROR stays 1.
6. ARESET asserted while in WR_B -> next cycle: all valids 0, BUSY=0, REQ_READY=0; a fresh write after reset completes normally.
